// File: rtl/serial_pattern_detector.sv
// Serial pattern detector: shifts enabled bits into a W-bit history and pulses
// match (plus a saturating hit count) whenever a fully populated window equals PATTERN.
module serial_pattern_detector #(
    parameter int             W       = 4,
    parameter logic [W-1:0]   PATTERN = 4'b1011,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    input  logic             clr,
    output logic             match,
    output logic [CNT_W-1:0] count,
    output logic             filling
);
    localparam int           NB_W    = $clog2(W + 1);
    localparam logic [NB_W-1:0] NB_FULL = NB_W'(W);

    localparam logic [0:0] S_FILL = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [W-1:0]     sr_q, sr_d, sr_next;
    logic [NB_W-1:0]  nbits_q, nbits_d, nbits_inc;
    logic [0:0]       state_q, state_d;
    logic             match_q, match_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             hit;

    assign sr_next   = {sr_q[W-2:0], din};
    assign nbits_inc = (nbits_q == NB_FULL) ? NB_FULL : nbits_q + NB_W'(1);
    // nbits gates the compare so reset zeros in sr never look like pattern bits
    assign hit       = en && (nbits_inc == NB_FULL) && (sr_next == PATTERN);

    always_comb begin
        sr_d    = sr_q;
        nbits_d = nbits_q;
        state_d = state_q;
        match_d = 1'b0;
        count_d = count_q;
        if (en) begin
            sr_d    = sr_next;
            nbits_d = nbits_inc;
            match_d = hit;
            state_d = (nbits_inc == NB_FULL) ? S_RUN : S_FILL;
            if (hit && !OVERLAP) begin
                nbits_d = '0;
                state_d = S_FILL;
            end
        end
        if (hit && (count_q != {CNT_W{1'b1}}))
            count_d = count_q + CNT_W'(1);
        if (clr)
            count_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q    <= '0;
            nbits_q <= '0;
            state_q <= S_FILL;
            match_q <= 1'b0;
            count_q <= '0;
        end else begin
            sr_q    <= sr_d;
            nbits_q <= nbits_d;
            state_q <= state_d;
            match_q <= match_d;
            count_q <= count_d;
        end
    end

    assign match   = match_q;
    assign count   = count_q;
    assign filling = (state_q == S_FILL);
endmodule

// File: tb/tb_serial_pattern_detector.sv
// Bench for serial_pattern_detector: three configurations share one stimulus stream
// and are compared against a window-history reference model plus hand-coded vectors.
module tb_serial_pattern_detector;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst, en, din, clr;
    logic [2:0] mo, fo;
    logic [7:0] co0, co1;
    logic [1:0] co2;

    always #5 clk = ~clk;

    serial_pattern_detector #(.W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .en(en), .din(din), .clr(clr),
        .match(mo[0]), .count(co0), .filling(fo[0]));
    serial_pattern_detector #(.W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .en(en), .din(din), .clr(clr),
        .match(mo[1]), .count(co1), .filling(fo[1]));
    serial_pattern_detector #(.W(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .en(en), .din(din), .clr(clr),
        .match(mo[2]), .count(co2), .filling(fo[2]));

    // Reference model: log of valid bits since the window (re)started
    bit [W-1:0] pat  [3] = '{4'b1011, 4'b1011, 4'b1111};
    bit         ov   [3] = '{1'b1, 1'b0, 1'b1};
    int         cmax [3] = '{255, 255, 3};
    bit         hist [3][4096];
    int         len  [3];
    int         mc   [3];
    bit         mm   [3];

    int errs = 0;
    int checks = 0;

    typedef struct {
        bit din;
        bit m0; int c0; bit f0;
        bit m1; int c1; bit f1;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int cnt_of(input int d);
        if (d == 0) return int'(co0);
        if (d == 1) return int'(co1);
        return int'(co2);
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 3; d++) begin
            len[d] = 0; mc[d] = 0; mm[d] = 1'b0;
        end
    endfunction

    function automatic void model_step(input bit e, input bit di, input bit c);
        for (int d = 0; d < 3; d++) begin
            mm[d] = 1'b0;
            if (e) begin
                hist[d][len[d]] = di;
                len[d]++;
                if (len[d] >= W) begin
                    bit ok;
                    ok = 1'b1;
                    for (int k = 0; k < W; k++)
                        if (hist[d][len[d]-W+k] != pat[d][W-1-k]) ok = 1'b0;
                    if (ok) begin
                        mm[d] = 1'b1;
                        if (mc[d] < cmax[d]) mc[d]++;
                        if (!ov[d]) len[d] = 0;
                    end
                end
            end
            if (c) mc[d] = 0;
        end
    endfunction

    task automatic check_all(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s match%0d", tag, d), int'(mo[d]), int'(mm[d]));
            chk($sformatf("%s count%0d", tag, d), cnt_of(d), mc[d]);
            chk($sformatf("%s filling%0d", tag, d), int'(fo[d]), (len[d] < W) ? 1 : 0);
        end
    endtask

    // Entered and left at a falling edge
    task automatic cyc(input bit e, input bit di, input bit c, input string tag);
        en = e; din = di; clr = c;
        @(posedge clk);
        model_step(e, di, c);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; clr = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        check_all("rst");
    endtask

    initial begin
        tbl = '{
            '{1'b1, 1'b0, 0, 1'b1, 1'b0, 0, 1'b1},
            '{1'b0, 1'b0, 0, 1'b1, 1'b0, 0, 1'b1},
            '{1'b1, 1'b0, 0, 1'b1, 1'b0, 0, 1'b1},
            '{1'b1, 1'b1, 1, 1'b0, 1'b1, 1, 1'b1},
            '{1'b0, 1'b0, 1, 1'b0, 1'b0, 1, 1'b1},
            '{1'b1, 1'b0, 1, 1'b0, 1'b0, 1, 1'b1},
            '{1'b1, 1'b1, 2, 1'b0, 1'b0, 1, 1'b1},
            '{1'b1, 1'b0, 2, 1'b0, 1'b0, 1, 1'b0},
            '{1'b0, 1'b0, 2, 1'b0, 1'b0, 1, 1'b0},
            '{1'b1, 1'b0, 2, 1'b0, 1'b0, 1, 1'b0},
            '{1'b1, 1'b1, 3, 1'b0, 1'b1, 2, 1'b1}
        };

        rst = 1'b1; en = 1'b0; din = 1'b0; clr = 1'b0;
        model_reset();
        #1;
        chk("por match", int'(mo[0]), 0);
        chk("por count", int'(co0), 0);
        chk("por filling", int'(fo[0]), 1);
        @(negedge clk);
        do_reset();

        // Async reset while match and count are nonzero
        cyc(1'b1, 1'b1, 1'b0, "pre");
        cyc(1'b1, 1'b0, 1'b0, "pre");
        cyc(1'b1, 1'b1, 1'b0, "pre");
        cyc(1'b1, 1'b1, 1'b0, "pre");
        chk("pre hit match", int'(mo[0]), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async match", int'(mo[0]), 0);
        chk("async count", int'(co0), 0);
        chk("async filling", int'(fo[0]), 1);
        @(negedge clk);
        do_reset();

        for (int i = 0; i < 11; i++) begin
            cyc(1'b1, tbl[i].din, 1'b0, "tbl");
            chk($sformatf("tbl[%0d] m0", i), int'(mo[0]), int'(tbl[i].m0));
            chk($sformatf("tbl[%0d] c0", i), int'(co0), tbl[i].c0);
            chk($sformatf("tbl[%0d] f0", i), int'(fo[0]), int'(tbl[i].f0));
            chk($sformatf("tbl[%0d] m1", i), int'(mo[1]), int'(tbl[i].m1));
            chk($sformatf("tbl[%0d] c1", i), int'(co1), tbl[i].c1);
            chk($sformatf("tbl[%0d] f1", i), int'(fo[1]), int'(tbl[i].f1));
        end

        // en gaps stretch the stream
        do_reset();
        for (int b = 0; b < 4; b++) begin
            bit bv;
            bv = (b == 1) ? 1'b0 : 1'b1;
            cyc(1'b1, bv, 1'b0, "gap");
            chk($sformatf("gap bit%0d m0", b), int'(mo[0]), (b == 3) ? 1 : 0);
            if (b < 3)
                for (int g = 0; g < 3; g++) begin
                    cyc(1'b0, 1'($urandom_range(1)), 1'b0, "gap");
                    chk("gap idle m0", int'(mo[0]), 0);
                end
        end

        // Saturation then clear on a hit edge
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b1, 1'b0, "sat");
            chk($sformatf("sat[%0d] c2", i), int'(co2), (i < 3) ? 0 : ((i - 2 > 3) ? 3 : i - 2));
        end
        cyc(1'b1, 1'b1, 1'b1, "clr");
        chk("clr c2", int'(co2), 0);
        chk("clr m2", int'(mo[2]), 1);

        // Random stream with occasional clr and reset
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) == 0) begin
                do_reset();
            end else begin
                cyc(1'($urandom_range(3) != 0),
                    1'($urandom_range(1)),
                    1'($urandom_range(31) == 0), "rnd");
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/serial_pattern_detector.md
# serial_pattern_detector

Consumes the registered serial bit stream produced by the single-bit D flip-flop stage and flags every occurrence of a fixed bit pattern. Incoming bits go into a shift history, and a small fill/run state machine ensures that only fully populated windows are compared. Each hit produces a one-cycle `match` pulse and increments a saturating hit counter. The block sits directly downstream of the DFF and takes that stage's `q` as its `din`.

## Interface
- `W`, 4, pattern length in bits (≥2)
- `PATTERN`, 4'b1011, pattern to detect; MSB is the oldest bit, LSB the newest
- `OVERLAP`, 1, 1 = overlapping matches allowed; 0 = history is discarded after a match
- `CNT_W`, 8, width of hit counter (≥1)

Ports:
- `clk`  input  1  rising-edge clock, sole clock domain
- `rst`  input  1  asynchronous, active-high reset
- `en`  input  1  `din` is sampled only on edges where `en`=1
- `din`  input  1  serial data, from the upstream DFF `q`
- `clr`  input  1  synchronous clear of `count` only
- `match`  output  1  one-cycle pulse per detected pattern, registered
- `count`  output  CNT_W  saturating number of matches since reset or `clr`
- `filling`  output  1  high while fewer than W valid bits are held

## Operation
- State:
  - `sr[W-1:0]`: shift history
  - `nbits`: 0..W, saturating
  - FSM states FILL (`nbits`<W) and RUN (`nbits`=W)
  - `filling` = (state==FILL)
- On an edge with `en`=1:
  - `sr_next` = {`sr[W-2:0]`, `din`}
  - `nbits_next` = min(`nbits`+1, W)
  - `hit` = (`nbits_next`==W) && (`sr_next`==PATTERN)
- `match` <= `hit`. On any edge with `en`=0, `match` <= 0 and `sr`, `nbits` and `count` hold.
- FSM transitions:
  - FILL→RUN when `nbits_next` reaches W.
  - RUN→FILL on `hit` only when OVERLAP=0; in that case `nbits` <= 0. `sr` still shifts, but its contents are ignored until W new bits arrive.
  - RUN stays RUN otherwise.
- Counter:
  - On `hit`, `count` <= `count`+1 unless `count` is all-ones; saturates, never wraps.
  - `clr`=1 forces `count` <= 0 regardless of `en` or `hit`. `clr` has priority over increment.
  - `clr` does not affect `sr`, `nbits`, FSM state or `match`.
- Reset (async, any time, including mid-pattern):
  - `sr`=0, `nbits`=0, state=FILL
  - `match`=0, `count`=0, `filling`=1
  - Zeros loaded into `sr` by reset never count as valid bits, even if PATTERN contains zeros.

## Timing
- Latency: `match` rises at the same clock edge that samples the last pattern bit and is high for exactly that one cycle.
- `count` updates on that same edge.
- Back-to-back pulses are possible when OVERLAP=1 and the pattern self-overlaps, e.g. PATTERN=4'b1111 with a run of ones gives `match`=1 on consecutive cycles.
- `en` gaps stretch the stream without breaking it. Bits separated by `en`=0 cycles are still contiguous in `sr`.
- Minimum distance between matches when OVERLAP=0: W enabled samples.
- `rst` assertion clears outputs immediately, without waiting for a clock edge. On deassertion, the first enabled edge samples bit 1 of a new window.

## Test plan
1. **Reset:** assert `rst` mid-stream → `match`=0, `count`=0, `filling`=1 immediately. After release, the stream 1,0,1 then 1 → no `match` before the 4th enabled bit, `match`=1 on the 4th.
2. **Overlap (defaults):** `en`=1, `din`=1,0,1,1,0,1,1 → `match` pulses after bit 4 and bit 7, `count`=2, `filling` falls after bit 4.
3. **Non-overlap (OVERLAP=0):** same stream → single pulse after bit 4, `count`=1, `filling`=1 for bits 5–7. Appending 1,0,1,1 gives a second pulse, `count`=2.
4. **`en` gaps:** the stream 1,0,1,1 with `en`=0 for 3 cycles between each bit → one pulse on the final enabled edge, `match`=0 during all gap cycles.
5. **Saturation and clear (CNT_W=2):** PATTERN=4'b1111, 10 consecutive ones → `count` goes 1,2,3 and stays 3. Assert `clr` on a hit edge → `count`=0 and `match`=1 on that edge.
